// File: rtl/tg_packet_sink_pkg.sv
// Shared flit layout for the DART traffic generator and packet sink.
`default_nettype none

package tg_packet_sink_pkg;

  localparam int TS_WIDTH     = 10;
  localparam int FLIT_WIDTH   = 36;
  localparam int FLIT_VALID   = 35;
  localparam int FLIT_HEAD    = 34;
  localparam int FLIT_TAIL    = 33;
  localparam int FLIT_TS_HI   = 32;
  localparam int FLIT_TS_LO   = 23;
  localparam int FLIT_MEASURE = 22;
  localparam int FLIT_DEST_HI = 21;
  localparam int FLIT_DEST_LO = 14;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } sink_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// Saturating accumulator: adds inc_i when en_i is high, holds at all-ones.
`default_nettype none

module sat_counter #(
  parameter int WIDTH     = 16,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [INC_WIDTH-1:0] inc_i,
  output logic [WIDTH-1:0]     cnt_o
);

  localparam int SUM_WIDTH = WIDTH + 1;

  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0] sum_w;

  always_comb begin
    sum_w = {1'b0, cnt_q} + SUM_WIDTH'(inc_i);
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/tg_packet_sink.sv
// Ejection-side packet sink: reassembles flits into packets, checks them
// against the node configuration and keeps saturating latency statistics.
`default_nettype none

module tg_packet_sink #(
  parameter int TS_WIDTH  = tg_packet_sink_pkg::TS_WIDTH,
  parameter int CNT_WIDTH = 16,
  parameter int LAT_WIDTH = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [TS_WIDTH-1:0]  sim_time,
  input  logic [35:0]          flit_in,
  output logic                 in_ready,
  input  logic [15:0]          config_in,
  input  logic                 config_in_valid,
  output logic [15:0]          config_out,
  output logic                 config_out_valid,
  output logic [CNT_WIDTH-1:0] pkts_received,
  output logic [CNT_WIDTH-1:0] pkts_measured,
  output logic [LAT_WIDTH-1:0] latency_sum,
  output logic [TS_WIDTH-1:0]  latency_max,
  output logic                 err_dest,
  output logic                 err_len,
  output logic                 err_proto
);

  import tg_packet_sink_pkg::*;

  sink_state_e         state_q, state_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                meas_q, meas_d;
  logic [7:0]          dest_q, dest_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          cfg_addr_q, cfg_len_q;
  logic [15:0]         cfg_out_q;
  logic                cfg_out_valid_q;
  logic                err_dest_q, err_len_q, err_proto_q;
  logic [TS_WIDTH-1:0] lat_max_q;

  logic                accept_w, head_w, tail_w, flit_meas_w;
  logic [TS_WIDTH-1:0] flit_ts_w;
  logic [7:0]          flit_dest_w;
  logic                fin_w, proto_w, fin_meas_w;
  logic [TS_WIDTH-1:0] fin_ts_w, lat_w;
  logic [7:0]          fin_dest_w, fin_cnt_w;
  logic                meas_done_w, dest_bad_w, len_bad_w;
  logic                unused_payload;

  assign in_ready    = enable;
  assign accept_w    = enable & flit_in[FLIT_VALID];
  assign head_w      = flit_in[FLIT_HEAD];
  assign tail_w      = flit_in[FLIT_TAIL];
  assign flit_ts_w   = TS_WIDTH'(flit_in[FLIT_TS_HI:FLIT_TS_LO]);
  assign flit_meas_w = flit_in[FLIT_MEASURE];
  assign flit_dest_w = flit_in[FLIT_DEST_HI:FLIT_DEST_LO];
  assign unused_payload = ^flit_in[13:0];

  // A head always (re)starts a packet; in RECV it also flags the dropped partial.
  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    meas_d     = meas_q;
    dest_d     = dest_q;
    cnt_d      = cnt_q;
    fin_w      = 1'b0;
    proto_w    = 1'b0;
    fin_ts_w   = ts_q;
    fin_meas_w = meas_q;
    fin_dest_w = dest_q;
    fin_cnt_w  = sat_inc8(cnt_q);
    if (accept_w) begin
      if (head_w) begin
        proto_w = (state_q == ST_RECV);
        ts_d    = flit_ts_w;
        meas_d  = flit_meas_w;
        dest_d  = flit_dest_w;
        cnt_d   = 8'd1;
        if (tail_w) begin
          fin_w      = 1'b1;
          fin_ts_w   = flit_ts_w;
          fin_meas_w = flit_meas_w;
          fin_dest_w = flit_dest_w;
          fin_cnt_w  = 8'd1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_RECV;
        end
      end else if (state_q == ST_IDLE) begin
        proto_w = 1'b1;
      end else begin
        cnt_d = sat_inc8(cnt_q);
        if (tail_w) begin
          fin_w   = 1'b1;
          state_d = ST_IDLE;
        end
      end
    end
  end

  assign lat_w       = sim_time - fin_ts_w;
  assign meas_done_w = fin_w & fin_meas_w;
  assign dest_bad_w  = fin_w & (fin_dest_w != cfg_addr_q);
  assign len_bad_w   = fin_w & (cfg_len_q != 8'd0) & (fin_cnt_w != cfg_len_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      ts_q            <= '0;
      meas_q          <= 1'b0;
      dest_q          <= '0;
      cnt_q           <= '0;
      cfg_addr_q      <= '0;
      cfg_len_q       <= '0;
      cfg_out_q       <= '0;
      cfg_out_valid_q <= 1'b0;
      err_dest_q      <= 1'b0;
      err_len_q       <= 1'b0;
      err_proto_q     <= 1'b0;
      lat_max_q       <= '0;
    end else begin
      state_q         <= state_d;
      ts_q            <= ts_d;
      meas_q          <= meas_d;
      dest_q          <= dest_d;
      cnt_q           <= cnt_d;
      cfg_out_valid_q <= config_in_valid;
      if (config_in_valid) begin
        cfg_out_q  <= {cfg_addr_q, cfg_len_q};
        cfg_addr_q <= config_in[15:8];
        cfg_len_q  <= config_in[7:0];
      end
      if (dest_bad_w) err_dest_q  <= 1'b1;
      if (len_bad_w)  err_len_q   <= 1'b1;
      if (proto_w)    err_proto_q <= 1'b1;
      if (meas_done_w && (lat_w > lat_max_q)) lat_max_q <= lat_w;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_cnt_received (
    .clk_i  (clock),
    .rst_ni (reset),
    .en_i   (fin_w),
    .inc_i  (1'b1),
    .cnt_o  (pkts_received)
  );

  sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_cnt_measured (
    .clk_i  (clock),
    .rst_ni (reset),
    .en_i   (meas_done_w),
    .inc_i  (1'b1),
    .cnt_o  (pkts_measured)
  );

  sat_counter #(.WIDTH(LAT_WIDTH), .INC_WIDTH(TS_WIDTH)) u_cnt_latency (
    .clk_i  (clock),
    .rst_ni (reset),
    .en_i   (meas_done_w),
    .inc_i  (lat_w),
    .cnt_o  (latency_sum)
  );

  assign config_out       = cfg_out_q;
  assign config_out_valid = cfg_out_valid_q;
  assign latency_max      = lat_max_q;
  assign err_dest         = err_dest_q;
  assign err_len          = err_len_q;
  assign err_proto        = err_proto_q;

endmodule

`default_nettype wire

// File: tb/tb_tg_packet_sink.sv
// Directed plus randomized checks of tg_packet_sink against a packet-level model.
`default_nettype none

module tb_tg_packet_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  sim_time = '0;
  logic [35:0] flit_in = '0;
  logic [15:0] config_in = '0;
  logic        config_in_valid = 1'b0;

  logic        in_ready, cov;
  logic [15:0] cfg_out;
  logic [15:0] rx, meas;
  logic [23:0] lsum;
  logic [9:0]  lmax;
  logic        edest, elen, eproto;

  logic        s_in_ready, s_cov;
  logic [15:0] s_cfg_out;
  logic [3:0]  s_rx, s_meas;
  logic [23:0] s_lsum;
  logic [9:0]  s_lmax;
  logic        s_edest, s_elen, s_eproto;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  tg_packet_sink dut (
    .clock(clock), .reset(reset), .enable(enable), .sim_time(sim_time),
    .flit_in(flit_in), .in_ready(in_ready), .config_in(config_in),
    .config_in_valid(config_in_valid), .config_out(cfg_out),
    .config_out_valid(cov), .pkts_received(rx), .pkts_measured(meas),
    .latency_sum(lsum), .latency_max(lmax), .err_dest(edest),
    .err_len(elen), .err_proto(eproto)
  );

  tg_packet_sink #(.CNT_WIDTH(4)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .sim_time(sim_time),
    .flit_in(flit_in), .in_ready(s_in_ready), .config_in(config_in),
    .config_in_valid(config_in_valid), .config_out(s_cfg_out),
    .config_out_valid(s_cov), .pkts_received(s_rx), .pkts_measured(s_meas),
    .latency_sum(s_lsum), .latency_max(s_lmax), .err_dest(s_edest),
    .err_len(s_elen), .err_proto(s_eproto)
  );

  // Packet-level reference state
  int m_rx, m_meas, m_sum, m_max, m_cfg, m_cout;
  bit m_cov, m_edest, m_elen, m_eproto;
  bit in_pkt;
  int p_ts, p_meas, p_dest, p_n;

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic logic [35:0] mk(input bit v, input bit h, input bit t,
                                     input logic [9:0] ts, input bit m,
                                     input logic [7:0] d, input logic [13:0] p);
    return {v, h, t, ts, m, d, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_rx = 0; m_meas = 0; m_sum = 0; m_max = 0; m_cfg = 0; m_cout = 0;
    m_cov = 0; m_edest = 0; m_elen = 0; m_eproto = 0; in_pkt = 0;
    p_ts = 0; p_meas = 0; p_dest = 0; p_n = 0;
  endtask

  task automatic model_edge();
    bit fin;
    int lat;
    fin = 0;
    if (enable && flit_in[35]) begin
      if (flit_in[34]) begin
        if (in_pkt) m_eproto = 1;
        p_ts = int'(flit_in[32:23]); p_meas = int'(flit_in[22]);
        p_dest = int'(flit_in[21:14]); p_n = 1; in_pkt = 1;
      end else if (!in_pkt) begin
        m_eproto = 1;
      end else begin
        p_n = sat(p_n + 1, 255);
      end
      if (in_pkt && flit_in[33]) begin
        fin = 1;
        in_pkt = 0;
      end
    end
    if (fin) begin
      m_rx++;
      if (p_dest != (m_cfg >> 8)) m_edest = 1;
      if ((m_cfg & 255) != 0 && p_n != (m_cfg & 255)) m_elen = 1;
      if (p_meas != 0) begin
        lat = ((int'(sim_time) - p_ts) % 1024 + 1024) % 1024;
        m_meas++;
        m_sum += lat;
        if (lat > m_max) m_max = lat;
      end
    end
    m_cov = config_in_valid;
    if (config_in_valid) begin
      m_cout = m_cfg;
      m_cfg  = int'(config_in);
    end
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, enable);
    chk("config_out", cfg_out, m_cout);
    chk("config_out_valid", cov, m_cov);
    chk("pkts_received", rx, sat(m_rx, 65535));
    chk("pkts_measured", meas, sat(m_meas, 65535));
    chk("latency_sum", lsum, sat(m_sum, 24'hFFFFFF));
    chk("latency_max", lmax, m_max);
    chk("err_dest", edest, m_edest);
    chk("err_len", elen, m_elen);
    chk("err_proto", eproto, m_eproto);
    chk("sat_pkts_received", s_rx, sat(m_rx, 15));
    chk("sat_pkts_measured", s_meas, sat(m_meas, 15));
    chk("sat_latency_sum", s_lsum, sat(m_sum, 24'hFFFFFF));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_clear();
    check_all();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic cfg(input logic [15:0] v);
    config_in = v; config_in_valid = 1'b1;
    cycle();
    config_in_valid = 1'b0;
  endtask

  int  g_left, nl;
  bit  h, v;

  initial begin
    model_clear();
    @(posedge clock);
    #1;
    do_reset();
    chk("reset_rx", rx, 0);
    chk("reset_cfg_out", cfg_out, 0);
    enable = 1'b1;

    // Configuration chain
    cfg(16'h0CA3);
    chk("cfg1_out", cfg_out, 16'h0000);
    chk("cfg1_valid", cov, 1);
    cycle();
    chk("cfg_valid_drop", cov, 0);
    cfg(16'h0104);
    chk("cfg2_out", cfg_out, 16'h0CA3);
    cfg(16'h0C03);

    // Clean measured 3-flit packet
    sim_time = 10'd7;  flit_in = mk(1, 1, 0, 10'd5, 1, 8'h0C, 14'h1); cycle();
    sim_time = 10'd8;  flit_in = mk(1, 0, 0, 10'd0, 0, 8'h00, 14'h2); cycle();
    flit_in = '0;
    for (int i = 9; i < 12; i++) begin sim_time = 10'(i); cycle(); end
    sim_time = 10'd12; flit_in = mk(1, 0, 1, 10'd0, 0, 8'h00, 14'h3); cycle();
    chk("clean_rx", rx, 1);
    chk("clean_meas", meas, 1);
    chk("clean_sum", lsum, 7);
    chk("clean_max", lmax, 7);
    chk("clean_errs", {edest, elen, eproto}, 3'b000);

    // Timestamp wrap
    sim_time = 10'd1022; flit_in = mk(1, 1, 0, 10'd1020, 1, 8'h0C, 14'h0); cycle();
    sim_time = 10'd1023; flit_in = mk(1, 0, 0, 10'd0, 0, 8'h00, 14'h0); cycle();
    sim_time = 10'd4;    flit_in = mk(1, 0, 1, 10'd0, 0, 8'h00, 14'h0); cycle();
    chk("wrap_max", lmax, 8);
    chk("wrap_sum", lsum, 15);

    // Wrong destination
    flit_in = mk(1, 1, 0, 10'd0, 0, 8'h0D, 14'h0); cycle();
    flit_in = mk(1, 0, 0, 10'd0, 0, 8'h00, 14'h0); cycle();
    flit_in = mk(1, 0, 1, 10'd0, 0, 8'h00, 14'h0); cycle();
    chk("dest_err", edest, 1);
    chk("dest_rx", rx, 3);
    chk("dest_len_ok", elen, 0);

    // Short packet
    flit_in = mk(1, 1, 0, 10'd0, 0, 8'h0C, 14'h0); cycle();
    flit_in = mk(1, 0, 1, 10'd0, 0, 8'h00, 14'h0); cycle();
    chk("len_err", elen, 1);
    chk("len_rx", rx, 4);

    // Body while idle
    chk("proto_before", eproto, 0);
    flit_in = mk(1, 0, 0, 10'd0, 1, 8'h0C, 14'h0); cycle();
    chk("proto_err", eproto, 1);
    chk("proto_rx", rx, 4);
    chk("proto_meas", meas, 2);

    // Reset mid-packet, then a lone tail must be a protocol error
    flit_in = mk(1, 1, 0, 10'd0, 1, 8'h0C, 14'h0); cycle();
    flit_in = '0;
    do_reset();
    chk("rst_rx", rx, 0);
    chk("rst_errs", {edest, elen, eproto}, 3'b000);
    flit_in = mk(1, 0, 1, 10'd0, 1, 8'h0C, 14'h0); cycle();
    chk("rst_idle_proto", eproto, 1);
    chk("rst_idle_rx", rx, 0);
    cfg(16'h0C03);

    // Enable held low mid-packet
    flit_in = mk(1, 1, 0, 10'd0, 0, 8'h0C, 14'h0); cycle();
    flit_in = mk(1, 0, 0, 10'd0, 0, 8'h00, 14'h0); cycle();
    flit_in = mk(1, 0, 1, 10'd0, 0, 8'h00, 14'h0);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stall_ready", in_ready, 0);
    end
    enable = 1'b1;
    cycle();
    chk("stall_rx", rx, 1);
    chk("stall_len", elen, 0);
    chk("stall_dest", edest, 0);

    // Randomized traffic
    flit_in = '0;
    g_left = 0;
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom % 5) != 0;
      sim_time = sim_time + 10'd1;
      if (($urandom % 40) == 0) begin
        config_in_valid = 1'b1;
        config_in = {(($urandom % 2) != 0) ? 8'h0C : 8'($urandom), 8'($urandom_range(0, 4))};
      end else begin
        config_in_valid = 1'b0;
      end
      v  = ($urandom % 4) != 0;
      h  = (g_left == 0) ? (($urandom % 20) != 0) : (($urandom % 30) == 0);
      nl = h ? int'($urandom_range(1, 4)) : g_left;
      flit_in = mk(v, h, nl <= 1, sim_time - 10'($urandom_range(0, 50)),
                   1'($urandom), (($urandom % 3) != 0) ? 8'h0C : 8'($urandom),
                   14'($urandom));
      cycle();
      if (enable && v) g_left = (nl == 0) ? 0 : nl - 1;
    end
    config_in_valid = 1'b0;
    enable = 1'b1;

    // Saturation on the narrow instance
    for (int i = 0; i < 17; i++) begin
      flit_in = mk(1, 1, 1, sim_time, 0, 8'h0C, 14'h0); cycle();
    end
    flit_in = '0;
    cycle();
    chk("sat_hold", s_rx, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tg_packet_sink.md
# tg_packet_sink

Ejection-side packet sink for the DART NoC simulator: the receiving end of the traffic generator's flit stream. It accepts flits leaving the network at a node and reassembles packets head-to-tail. It checks each packet's destination and length against its configuration. For measured packets it computes latency from the head timestamp and the current simulation time, and it keeps saturating statistics counters.

## Interface
Parameters:
- `TS_WIDTH`, 10, timestamp and simulation-time width.
- `CNT_WIDTH`, 16, width of the packet counters.
- `LAT_WIDTH`, 24, width of the latency accumulator.

Ports:
- `clock` in 1, single clock, rising edge.
- `reset` in 1, asynchronous, active-low; all state is cleared while low.
- `enable` in 1, sink is allowed to accept flits.
- `sim_time` in TS_WIDTH, current simulation time.
- `flit_in` in 36, flit bus:
  - [35] valid, [34] head, [33] tail, [32:23] injection timestamp, [22] measure, [21:14] dest, [13:0] payload.
- `in_ready` out 1, flit is accepted this cycle.
- `config_in` in 16, configuration word: [15:8] node address, [7:0] expected flits per packet.
- `config_in_valid` in 1, load `config_in`.
- `config_out` out 16, previously held configuration (chain output).
- `config_out_valid` out 1, `config_out` is valid.
- `pkts_received` out CNT_WIDTH, completed packets.
- `pkts_measured` out CNT_WIDTH, completed packets with the measure bit set.
- `latency_sum` out LAT_WIDTH, sum of measured-packet latencies.
- `latency_max` out TS_WIDTH, maximum measured latency.
- `err_dest` out 1, sticky; a packet's dest differed from the node address.
- `err_len` out 1, sticky; a packet's flit count differed from the expected count.
- `err_proto` out 1, sticky; a head arrived mid-packet or a body flit arrived while IDLE.

## Operation
- Accept condition: `in_ready = enable`. A flit is consumed when `in_ready & flit_in[35]`.
- FSM states:
  - **IDLE**: on an accepted head, latch the timestamp, measure bit and dest, and set `flit_cnt` to 1.
    - If that head also has tail set, it is a single-flit packet: finish the packet, stay in IDLE.
    - Otherwise go to RECV.
  - **RECV**: each accepted flit increments `flit_cnt`.
    - Accepted tail: finish the packet, go to IDLE.
    - Accepted head: set `err_proto`, drop the partial packet without counting it, restart with the new head.
  - **IDLE**, accepted non-head flit: set `err_proto` and drop the flit.
- Finishing a packet, registered in a one-stage stats pipe:
  - `pkts_received` increments.
  - Latched dest differs from `cfg_addr`: set `err_dest`.
  - Final `flit_cnt` differs from `cfg_len`: set `err_len`. `cfg_len` of 0 disables this check.
  - If the measure bit was set:
    - latency = (`sim_time` at tail acceptance − head timestamp), modulo 2^TS_WIDTH (wrap-safe).
    - `pkts_measured` increments and `latency_sum` adds the latency.
    - `latency_max` takes the larger of itself and the latency.
- All counters saturate at all-ones and never wrap. `flit_cnt` saturates at 255.
- Configuration chain: on `config_in_valid`, `config_out` is loaded with the old `{cfg_addr, cfg_len}` and the new value is latched. `config_out_valid` is a one-cycle registered copy of `config_in_valid`.
- `enable` low: flits are not accepted and FSM state is held (a partial packet resumes).

## Timing
- Reset values: FSM IDLE; all counters 0; all `err_*` 0; `cfg` = 0x0000; `config_out` 0; `config_out_valid` 0.
- Statistics outputs change exactly 1 cycle after the tail is accepted.
- Error flags update in the same cycle as the statistics, except `err_proto`, which is set 1 cycle after the offending flit.
- Configuration write and packet completion in the same cycle: the checks use the old `cfg`.
- Reset asserted mid-packet: the partial packet is discarded; nothing is counted.
- Back-to-back packets (tail then head on the next cycle) are handled at full rate.

## Structure
- Shared package or const include holds the flit field positions (`FLIT_VALID`, `FLIT_HEAD`, `FLIT_TAIL`, timestamp, measure and dest ranges) and `TS_WIDTH`. This is the same definition the traffic generator uses.
- One sub-module, `sat_counter` (parameterised width, increment/add, saturating), is instantiated for every counter.

## Test plan
- Configuration: drive `config_in` = 0x0CA3 with valid for 1 cycle.
  - Next cycle: `config_out` = 0x0000, `config_out_valid` = 1.
  - A second load of 0x0104 shifts 0x0CA3 out.
- Clean measured packet: head ts = 5 at `sim_time` 7, body, tail at `sim_time` 12, dest 0x0C, `cfg_len` 3.
  - One cycle after the tail: `pkts_received` = 1, `pkts_measured` = 1, `latency_sum` = 7, `latency_max` = 7, no errors.
- Timestamp wrap: head ts = 1020, tail at `sim_time` 4.
  - Latency = 8; `latency_max` = 8.
- Wrong packets:
  - dest 0x0D: `err_dest` = 1, `pkts_received` still increments.
  - A 2-flit packet with `cfg_len` 3: `err_len` = 1.
  - A body flit while IDLE: `err_proto` = 1 and no counters change.
- Mid-packet disruptions:
  - Pull `reset` low after the head of a 3-flit packet: all outputs return to 0 and the FSM returns to IDLE.
  - `enable` = 0 for 4 cycles mid-packet: `in_ready` = 0 throughout; the packet completes correctly afterwards.
- Saturation: CNT_WIDTH=4 with 17 packets: `pkts_received` holds at 15.
